// File: rtl/move_sequencer_if.sv
// ----------------------------------------------------------------------------
// move_sequencer_if
// Purpose : bundles the place/new_game request inputs, the board-RAM port and
//           the game status outputs of move_sequencer.
// Modports: master - move_sequencer (drives RAM port and status)
//           slave  - environment (drives requests and RAM read data)
// Signals : new_game, place, mouse_pos[ADDR_W], ram_addr[ADDR_W], ram_rd_data[2],
//           ram_we, ram_wr_data[2], player, busy, move_ok, move_rej,
//           move_cnt[ADDR_W+1], game_over, turn_left[TURN_W] (TURN_TIMER_EN only)
// Config  : TURN_TIMER_EN adds the turn_left status signal.
// ----------------------------------------------------------------------------
interface move_sequencer_if #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned TURN_W = 31
);
   logic              new_game;
   logic              place;
   logic [ADDR_W-1:0] mouse_pos;
   logic [ADDR_W-1:0] ram_addr;
   logic [1:0]        ram_rd_data;
   logic              ram_we;
   logic [1:0]        ram_wr_data;
   logic              player;
   logic              busy;
   logic              move_ok;
   logic              move_rej;
   logic [ADDR_W:0]   move_cnt;
   logic              game_over;
`ifdef TURN_TIMER_EN
   logic [TURN_W-1:0] turn_left;
`endif

   modport master (
      input  new_game, place, mouse_pos, ram_rd_data,
      output ram_addr, ram_we, ram_wr_data, player, busy,
             move_ok, move_rej, move_cnt, game_over
`ifdef TURN_TIMER_EN
      , output turn_left
`endif
   );

   modport slave (
      output new_game, place, mouse_pos, ram_rd_data,
      input  ram_addr, ram_we, ram_wr_data, player, busy,
             move_ok, move_rej, move_cnt, game_over
`ifdef TURN_TIMER_EN
      , input turn_left
`endif
   );
endinterface

// File: rtl/move_sequencer.sv
// ----------------------------------------------------------------------------
// move_sequencer
// Purpose : turn/move controller between the mouse cell picker and the board
//           cell RAM. Clears the board, serialises place requests, checks the
//           target cell, writes the owner code, alternates players, counts
//           moves and flags game over.
// Ports   : clk  - clk_65 domain clock
//           rst  - asynchronous reset, active-low
//           bus  - move_sequencer_if.master (requests, RAM port, status)
// Config  : TURN_TIMER_EN enables a per-turn time limit (TURN_TICKS cycles);
//           an idle turn that runs out is forfeited with a move_rej pulse.
// ----------------------------------------------------------------------------
module move_sequencer #(
   parameter int unsigned CELLS      = 64,
   parameter int unsigned ADDR_W     = 6,
   parameter int unsigned TURN_TICKS = 1_950_000_000
) (
   input  logic            clk,
   input  logic            rst,
   move_sequencer_if.master bus
);
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CELLS_C = CNT_W'(CELLS);

   typedef enum logic [2:0] {
      S_CLEAR, S_IDLE, S_READ, S_CHECK, S_WRITE, S_OVER
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_clr_cnt;
   logic [ADDR_W-1:0] r_ram_addr;
   logic              r_ram_we;
   logic [1:0]        r_ram_wr_data;
   logic              r_player;
   logic              r_busy;
   logic              r_move_ok;
   logic              r_move_rej;
   logic [CNT_W-1:0]  r_move_cnt;
   logic              r_game_over;

   logic              w_pos_oob;
   logic [CNT_W-1:0]  w_cnt_inc;

   // Positions beyond the board are rejected without touching the RAM.
   assign w_pos_oob = ({1'b0, bus.mouse_pos} >= CELLS_C);
   // Saturating move count.
   assign w_cnt_inc = (r_move_cnt == CELLS_C) ? r_move_cnt : r_move_cnt + CNT_W'(1);

`ifdef TURN_TIMER_EN
   localparam int unsigned TURN_W = $clog2(TURN_TICKS);
   logic [TURN_W-1:0] r_turn_cnt;
   assign bus.turn_left = TURN_W'(TURN_TICKS - 1) - r_turn_cnt;
`endif

   // Sequencer FSM; every output is a register updated with the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= S_CLEAR;
         r_clr_cnt     <= '0;
         r_ram_addr    <= '0;
         r_ram_we      <= 1'b0;
         r_ram_wr_data <= 2'b00;
         r_player      <= 1'b0;
         r_busy        <= 1'b1;
         r_move_ok     <= 1'b0;
         r_move_rej    <= 1'b0;
         r_move_cnt    <= '0;
         r_game_over   <= 1'b0;
`ifdef TURN_TIMER_EN
         r_turn_cnt    <= '0;
`endif
      end else begin
         r_move_ok  <= 1'b0;
         r_move_rej <= 1'b0;
         if (bus.new_game) begin
            // Restart wins over anything in flight; the first clear write is issued now.
            r_state       <= S_CLEAR;
            r_clr_cnt     <= CNT_W'(1);
            r_ram_addr    <= '0;
            r_ram_we      <= 1'b1;
            r_ram_wr_data <= 2'b00;
            r_busy        <= 1'b1;
            r_player      <= 1'b0;
            r_move_cnt    <= '0;
            r_game_over   <= 1'b0;
`ifdef TURN_TIMER_EN
            r_turn_cnt    <= '0;
`endif
         end else begin
            case (r_state)
               S_CLEAR: begin
                  if (r_clr_cnt < CELLS_C) begin
                     r_ram_we      <= 1'b1;
                     r_ram_wr_data <= 2'b00;
                     r_ram_addr    <= r_clr_cnt[ADDR_W-1:0];
                     r_clr_cnt     <= r_clr_cnt + CNT_W'(1);
                  end else begin
                     r_ram_we   <= 1'b0;
                     r_ram_addr <= '0;
                     r_state    <= S_IDLE;
                     r_busy     <= 1'b0;
                     r_player   <= 1'b0;
                     r_move_cnt <= '0;
`ifdef TURN_TIMER_EN
                     r_turn_cnt <= '0;
`endif
                  end
               end
               S_IDLE: begin
`ifdef TURN_TIMER_EN
                  // Expired turn is forfeited; a place in the same cycle is dropped.
                  if (r_turn_cnt == TURN_W'(TURN_TICKS - 1)) begin
                     r_player   <= ~r_player;
                     r_move_rej <= 1'b1;
                     r_turn_cnt <= '0;
                  end else begin
                     r_turn_cnt <= r_turn_cnt + TURN_W'(1);
`endif
                  if (bus.place) begin
                     if (w_pos_oob) begin
                        r_move_rej <= 1'b1;
                     end else begin
                        r_ram_addr <= bus.mouse_pos;
                        r_state    <= S_READ;
                        r_busy     <= 1'b1;
                     end
                  end
`ifdef TURN_TIMER_EN
                  end
`endif
               end
               S_READ: begin
                  r_state <= S_CHECK;
               end
               S_CHECK: begin
                  if (bus.ram_rd_data == 2'b00) begin
                     r_state       <= S_WRITE;
                     r_ram_we      <= 1'b1;
                     r_ram_wr_data <= r_player ? 2'b10 : 2'b01;
                     r_move_ok     <= 1'b1;
                  end else begin
                     r_move_rej <= 1'b1;
                     r_state    <= S_IDLE;
                     r_busy     <= 1'b0;
                  end
               end
               S_WRITE: begin
                  r_ram_we   <= 1'b0;
                  r_player   <= ~r_player;
                  r_move_cnt <= w_cnt_inc;
                  r_busy     <= 1'b0;
`ifdef TURN_TIMER_EN
                  r_turn_cnt <= '0;
`endif
                  if (w_cnt_inc == CELLS_C) begin
                     r_state     <= S_OVER;
                     r_game_over <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
               S_OVER: begin
                  if (bus.place) r_move_rej <= 1'b1;
               end
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.ram_addr    = r_ram_addr;
   assign bus.ram_we      = r_ram_we;
   assign bus.ram_wr_data = r_ram_wr_data;
   assign bus.player      = r_player;
   assign bus.busy        = r_busy;
   assign bus.move_ok     = r_move_ok;
   assign bus.move_rej    = r_move_rej;
   assign bus.move_cnt    = r_move_cnt;
   assign bus.game_over   = r_game_over;

endmodule

// File: tb/tb_move_sequencer.sv
// ----------------------------------------------------------------------------
// tb_move_sequencer
// Purpose : self-checking bench for move_sequencer with a behavioural board RAM
//           and a board/turn reference model.
// ----------------------------------------------------------------------------
module tb_move_sequencer;
   localparam int CELLS = 64;

   logic clk = 1'b0;
   logic rst = 1'b0;

   move_sequencer_if #(.ADDR_W(6)) bus ();

   move_sequencer #(.CELLS(CELLS), .ADDR_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Board RAM: synchronous write, read data one cycle after the address.
   logic [1:0] mem [0:63];
   always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wr_data;
      bus.ram_rd_data <= mem[bus.ram_addr];
   end

   int total = 0;
   int bad   = 0;

   // Reference model of the game.
   bit [1:0] m_board [CELLS];
   bit       m_player;
   int       m_cnt;
   bit       m_over;

   typedef struct {
      int ok_cyc;  int rej_cyc; int we_cnt; int we_addr; int we_data;
      int player;  int cnt;     int over;
   } exp_t;

   typedef struct {
      int pos; int drop; int ok_cyc; int rej_cyc; int we_data; int player; int cnt;
   } vec_t;

   function automatic void chk(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic void model_clear;
      for (int i = 0; i < CELLS; i++) m_board[i] = 2'b00;
      m_player = 1'b0;
      m_cnt    = 0;
      m_over   = 1'b0;
   endfunction

   // Outcome of one place request; cycle numbers count from the place cycle.
   function automatic exp_t model_place(int pos);
      exp_t e;
      e.ok_cyc = 0; e.rej_cyc = 0; e.we_cnt = 0; e.we_addr = pos; e.we_data = 0;
      if (m_over || pos >= CELLS) begin
         e.rej_cyc = 1;
      end else if (m_board[pos] != 2'b00) begin
         e.rej_cyc = 3;
      end else begin
         e.ok_cyc  = 3;
         e.we_cnt  = 1;
         e.we_data = m_player ? 2 : 1;
         m_board[pos] = 2'(e.we_data);
         m_player = !m_player;
         m_cnt++;
         m_over = (m_cnt == CELLS);
      end
      e.player = int'(m_player);
      e.cnt    = m_cnt;
      e.over   = int'(m_over);
      return e;
   endfunction

   // One place pulse, optionally a second (dropped) one while busy at cycle drop.
   task automatic do_place(input string name, input int pos, input int drop, input exp_t e);
      int ok_n = 0, rej_n = 0, ok_c = 0, rej_c = 0, we_n = 0, wa = 0, wd = 0;
      bus.mouse_pos = 6'(pos);
      bus.place     = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick;
         bus.place = 1'b0;
         if (bus.move_ok)  begin ok_n++;  if (ok_c == 0)  ok_c = k;  end
         if (bus.move_rej) begin rej_n++; if (rej_c == 0) rej_c = k; end
         if (bus.ram_we)   begin we_n++; wa = int'(bus.ram_addr); wd = int'(bus.ram_wr_data); end
         if (k == drop) begin
            bus.place     = 1'b1;
            bus.mouse_pos = 6'(pos + 1);
         end
      end
      chk({name, "/ok_cyc"},  (ok_n  > 1) ? 100 + ok_n  : ok_c,  e.ok_cyc);
      chk({name, "/rej_cyc"}, (rej_n > 1) ? 100 + rej_n : rej_c, e.rej_cyc);
      chk({name, "/we_cnt"}, we_n, e.we_cnt);
      if (e.we_cnt == 1) begin
         chk({name, "/we_addr"}, wa, e.we_addr);
         chk({name, "/we_data"}, wd, e.we_data);
      end
      chk({name, "/player"},    int'(bus.player),    e.player);
      chk({name, "/move_cnt"},  int'(bus.move_cnt),  e.cnt);
      chk({name, "/game_over"}, int'(bus.game_over), e.over);
      chk({name, "/busy"},      int'(bus.busy),      0);
   endtask

   // Follows a board clear from the current cycle until busy drops.
   task automatic check_clear(input string name, input bit hold);
      int idx = 0, pulses = 0;
      bit bad_seq = 1'b0, started = 1'b0, done = 1'b0;
      if (hold) begin
         bus.place     = 1'b1;
         bus.mouse_pos = 6'd3;
      end
      for (int c = 0; c < 300 && !done; c++) begin
         if (c > 0) tick;
         if (bus.move_ok || bus.move_rej) pulses++;
         if (bus.ram_we) begin
            if (int'(bus.ram_addr) != idx || bus.ram_wr_data != 2'b00) bad_seq = 1'b1;
            idx++;
            started = 1'b1;
         end else if (started && bus.busy) begin
            bad_seq = 1'b1;
         end
         if (!bus.busy) begin
            done      = 1'b1;
            bus.place = 1'b0;
         end
      end
      bus.place = 1'b0;
      chk({name, "/finished"},  int'(done), 1);
      chk({name, "/writes"},    idx, CELLS);
      chk({name, "/sequence"},  int'(bad_seq), 0);
      chk({name, "/pulses"},    pulses, 0);
      chk({name, "/player"},    int'(bus.player), 0);
      chk({name, "/move_cnt"},  int'(bus.move_cnt), 0);
      chk({name, "/game_over"}, int'(bus.game_over), 0);
      if (hold) begin
         tick;
         chk({name, "/ignored_rej"},  int'(bus.move_rej), 0);
         chk({name, "/ignored_busy"}, int'(bus.busy), 0);
      end
   endtask

   vec_t tbl [7];

   initial begin
      exp_t e;
      int   iter, pos, drop;

      tbl[0] = '{pos: 10, drop: 0, ok_cyc: 3, rej_cyc: 0, we_data: 1, player: 1, cnt: 1};
      tbl[1] = '{pos: 10, drop: 1, ok_cyc: 0, rej_cyc: 3, we_data: 0, player: 1, cnt: 1};
      tbl[2] = '{pos: 20, drop: 2, ok_cyc: 3, rej_cyc: 0, we_data: 2, player: 0, cnt: 2};
      tbl[3] = '{pos: 20, drop: 0, ok_cyc: 0, rej_cyc: 3, we_data: 0, player: 0, cnt: 2};
      tbl[4] = '{pos: 10, drop: 2, ok_cyc: 0, rej_cyc: 3, we_data: 0, player: 0, cnt: 2};
      tbl[5] = '{pos: 63, drop: 0, ok_cyc: 3, rej_cyc: 0, we_data: 1, player: 1, cnt: 3};
      tbl[6] = '{pos: 0,  drop: 1, ok_cyc: 3, rej_cyc: 0, we_data: 2, player: 0, cnt: 4};

      bus.new_game  = 1'b0;
      bus.place     = 1'b0;
      bus.mouse_pos = '0;
      rst = 1'b0;
      repeat (3) tick;
      chk("rst/busy",      int'(bus.busy), 1);
      chk("rst/ram_we",    int'(bus.ram_we), 0);
      chk("rst/ram_addr",  int'(bus.ram_addr), 0);
      chk("rst/wr_data",   int'(bus.ram_wr_data), 0);
      chk("rst/player",    int'(bus.player), 0);
      chk("rst/move_cnt",  int'(bus.move_cnt), 0);
      chk("rst/game_over", int'(bus.game_over), 0);
      chk("rst/pulses",    int'(bus.move_ok) + int'(bus.move_rej), 0);

      rst = 1'b1;
      check_clear("clear_rst", 1'b1);
      model_clear();

      // Directed vectors.
      for (int i = 0; i < 7; i++) begin
         exp_t te;
         e = model_place(tbl[i].pos);
         te.ok_cyc  = tbl[i].ok_cyc;
         te.rej_cyc = tbl[i].rej_cyc;
         te.we_cnt  = (tbl[i].ok_cyc != 0) ? 1 : 0;
         te.we_addr = tbl[i].pos;
         te.we_data = tbl[i].we_data;
         te.player  = tbl[i].player;
         te.cnt     = tbl[i].cnt;
         te.over    = 0;
         repeat (i % 3) tick;
         do_place($sformatf("vec%0d", i), tbl[i].pos, tbl[i].drop, te);
      end

      // Random play until the board is full.
      iter = 0;
      while (!m_over && iter < 1500) begin
         repeat ($urandom_range(0, 2)) tick;
         pos  = int'($urandom_range(0, CELLS - 1));
         drop = int'($urandom_range(0, 2));
         e = model_place(pos);
         do_place($sformatf("rnd%0d", iter), pos, drop, e);
         iter++;
      end
      chk("full/game_over", int'(bus.game_over), 1);
      chk("full/move_cnt",  int'(bus.move_cnt), CELLS);

      e = model_place(17);
      do_place("over_extra0", 17, 0, e);
      tick;
      e = model_place(10);
      do_place("over_extra1", 10, 0, e);

      // New game from OVER.
      bus.new_game = 1'b1;
      tick;
      bus.new_game = 1'b0;
      check_clear("clear_ng", 1'b0);
      model_clear();

      // new_game together with place while the move is in CHECK.
      bus.mouse_pos = 6'd5;
      bus.place     = 1'b1;
      tick;
      bus.place = 1'b0;
      tick;
      bus.new_game  = 1'b1;
      bus.place     = 1'b1;
      bus.mouse_pos = 6'd7;
      tick;
      bus.new_game = 1'b0;
      bus.place    = 1'b0;
      chk("ng_check/move_ok",  int'(bus.move_ok), 0);
      chk("ng_check/move_rej", int'(bus.move_rej), 0);
      chk("ng_check/ram_we",   int'(bus.ram_we), 1);
      chk("ng_check/ram_addr", int'(bus.ram_addr), 0);
      chk("ng_check/wr_data",  int'(bus.ram_wr_data), 0);
      check_clear("clear_ck", 1'b0);
      e = model_place(5);
      do_place("after_ck", 5, 0, e);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
